// File: rtl/enc_frame_ctrl_if.sv
// Bundle between the upstream bit source, the frame controller and the
// convolutional encoder's control inputs.
interface enc_frame_ctrl_if #(
  parameter int LEN_W = 8
) ();
  logic             start_sig;
  logic [LEN_W-1:0] len_sig;
  logic             in_valid_sig;
  logic             in_bit_sig;
  logic             in_ready_sig;
  logic             enc_clr_sig;
  logic             enc_en_sig;
  logic             enc_bit_sig;
  logic             busy_sig;
  logic             done_sig;

  // Master is the side that requests frames and supplies payload bits.
  modport master (
    output start_sig, len_sig, in_valid_sig, in_bit_sig,
    input  in_ready_sig, enc_clr_sig, enc_en_sig, enc_bit_sig, busy_sig, done_sig
  );

  modport slave (
    input  start_sig, len_sig, in_valid_sig, in_bit_sig,
    output in_ready_sig, enc_clr_sig, enc_en_sig, enc_bit_sig, busy_sig, done_sig
  );
endinterface

// File: rtl/enc_frame_ctrl.sv
// Frame sequencer for the convolutional encoder: clears the encoder, paces
// len payload bits at one per NUM clocks, then appends TAIL zero flush bits.
module enc_frame_ctrl #(
  parameter int NUM   = 4,
  parameter int TAIL  = 2,
  parameter int LEN_W = 8
) (
  input  logic            clk_sig,
  input  logic            rst_sig,
  enc_frame_ctrl_if.slave bus
);

  localparam int CW = $clog2(NUM);
  localparam int TW = $clog2(TAIL + 1);
  localparam logic [CW-1:0]    CNT_LAST  = CW'(NUM - 1);
  localparam logic [TW-1:0]    TAIL_LAST = TW'(TAIL - 1);
  localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_DATA,
    S_FLUSH,
    S_DONE
  } state_e;

  state_e           state_q,    state_d;
  logic [LEN_W-1:0] len_q,      len_d;
  logic [LEN_W-1:0] acc_cnt_q,  acc_cnt_d;
  logic [LEN_W-1:0] emit_cnt_q, emit_cnt_d;
  logic [TW-1:0]    tail_cnt_q, tail_cnt_d;
  logic [CW-1:0]    cnt_q,      cnt_d;
  logic             hold_bit_q, hold_bit_d;
  logic             hold_v_q,   hold_v_d;

  logic tick;
  logic in_ready;
  logic load;
  logic enc_clr;
  logic enc_en;
  logic enc_bit;
  logic done;

  // Tick and ready depend only on registered state; in_valid never reaches an output.
  assign tick     = (state_q == S_DATA) && (cnt_q == CNT_LAST) && hold_v_q;
  assign in_ready = (state_q == S_DATA) && (acc_cnt_q < len_q) && (!hold_v_q || tick);
  assign load     = in_ready && bus.in_valid_sig;

  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    len_d      = len_q;
    acc_cnt_d  = acc_cnt_q;
    emit_cnt_d = emit_cnt_q;
    tail_cnt_d = tail_cnt_q;
    cnt_d      = cnt_q;
    hold_bit_d = hold_bit_q;
    hold_v_d   = hold_v_q;
    enc_clr    = 1'b0;
    enc_en     = 1'b0;
    enc_bit    = 1'b0;
    done       = 1'b0;

    // A tick and a load in the same cycle hand over directly to the new bit.
    if (load) begin
      hold_bit_d = bus.in_bit_sig;
      hold_v_d   = 1'b1;
      acc_cnt_d  = acc_cnt_q + LEN_ONE;
    end else if (tick) begin
      hold_v_d   = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (bus.start_sig && (bus.len_sig != '0)) begin
          len_d      = bus.len_sig;
          acc_cnt_d  = '0;
          emit_cnt_d = '0;
          tail_cnt_d = '0;
          cnt_d      = '0;
          hold_v_d   = 1'b0;
          state_d    = S_CLEAR;
        end
      end

      S_CLEAR: begin
        enc_clr = 1'b1;
        cnt_d   = '0;
        state_d = S_DATA;
      end

      S_DATA: begin
        if (tick) begin
          enc_en     = 1'b1;
          enc_bit    = hold_bit_q;
          emit_cnt_d = emit_cnt_q + LEN_ONE;
          cnt_d      = '0;
          if (emit_cnt_q == len_q - LEN_ONE) begin
            state_d = S_FLUSH;
          end
        end else if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + CW'(1);
        end
        // cnt parks at CNT_LAST while the holding register is empty.
      end

      S_FLUSH: begin
        if (cnt_q == CNT_LAST) begin
          enc_en     = 1'b1;
          cnt_d      = '0;
          tail_cnt_d = tail_cnt_q + TW'(1);
          if (tail_cnt_q == TAIL_LAST) begin
            state_d = S_DONE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sig) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
    // independent of statement order.
    if (rst_sig) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      acc_cnt_q  <= '0;
      emit_cnt_q <= '0;
      tail_cnt_q <= '0;
      cnt_q      <= '0;
      hold_bit_q <= 1'b0;
      hold_v_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      acc_cnt_q  <= acc_cnt_d;
      emit_cnt_q <= emit_cnt_d;
      tail_cnt_q <= tail_cnt_d;
      cnt_q      <= cnt_d;
      hold_bit_q <= hold_bit_d;
      hold_v_q   <= hold_v_d;
    end
  end

  assign bus.in_ready_sig = in_ready;
  assign bus.enc_clr_sig  = enc_clr;
  assign bus.enc_en_sig   = enc_en;
  assign bus.enc_bit_sig  = enc_bit;
  assign bus.busy_sig     = (state_q != S_IDLE);
  assign bus.done_sig     = done;

endmodule

// File: tb/tb_enc_frame_ctrl.sv
// Scoreboard bench for enc_frame_ctrl: a timing model pushes the expected
// clear/strobe/done events, and a negedge monitor pops and compares them.
module tb_enc_frame_ctrl;

  localparam int NUM   = 4;
  localparam int TAIL  = 2;
  localparam int LEN_W = 8;
  localparam int NOCUT = 1 << 30;

  typedef enum int {EV_CLR, EV_EN, EV_DONE} ev_kind_e;
  typedef struct {
    ev_kind_e kind;
    int       c;
    logic     b;
  } ev_t;
  typedef struct {
    int c;
    int len;
  } st_t;

  logic clk_sig = 1'b0;
  logic rst_sig;

  enc_frame_ctrl_if #(.LEN_W(LEN_W)) bus ();

  enc_frame_ctrl #(.NUM(NUM), .TAIL(TAIL), .LEN_W(LEN_W)) dut (
    .clk_sig (clk_sig),
    .rst_sig (rst_sig),
    .bus     (bus)
  );

  always #5 clk_sig = ~clk_sig;

  int  cyc = 0;
  int  n_chk = 0;
  int  n_fail = 0;
  int  hs_count = 0;
  int  hs_base = 0;
  int  pl_idx = 0;
  int  valid_from = 0;
  int  rst_cyc = -1;
  bit  mon_en = 1'b0;
  bit  busy_map [0:19999];
  bit  pl [$];
  st_t starts [$];
  ev_t exp_q [$];

  always @(posedge clk_sig) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, act, exp);
    end
  endtask

  task automatic pop_cmp(input ev_kind_e k, input logic b);
    ev_t e;
    if (exp_q.size() == 0) begin
      check($sformatf("unexpected_ev_%0d", int'(k)), cyc, 32'hFFFF_FFFF);
    end else begin
      e = exp_q.pop_front();
      check("ev_kind", int'(k), int'(e.kind));
      check("ev_cycle", cyc, e.c);
      check("ev_bit", b, e.b);
    end
  endtask

  // Monitor: counts handshakes and compares DUT events against the scoreboard.
  always @(negedge clk_sig) begin
    if (!rst_sig && bus.in_valid_sig && bus.in_ready_sig) hs_count++;
    if (mon_en) begin
      check("busy", bus.busy_sig, busy_map[cyc]);
      if (!bus.enc_en_sig) check("bit_idle", bus.enc_bit_sig, 1'b0);
      if (bus.enc_clr_sig) pop_cmp(EV_CLR, 1'b0);
      if (bus.enc_en_sig)  pop_cmp(EV_EN, bus.enc_bit_sig);
      if (bus.done_sig)    pop_cmp(EV_DONE, 1'b0);
    end
  end

  task automatic push_ev(input ev_kind_e k, input int c, input logic b, input int cut);
    if (c <= cut) exp_q.push_back('{kind: k, c: c, b: b});
  endtask

  // Timing model: bit k is accepted once the hold slot is free (frame start or
  // previous strobe) and valid is up; its strobe is the later of the nominal
  // slot and the cycle after acceptance.
  task automatic model_frame(input int t0, input int len, input int base,
                             input int vfrom, input int cut, output int d);
    int s, h, nom;
    push_ev(EV_CLR, t0 + 1, 1'b0, cut);
    nom = t0 + 1 + NUM;
    h   = (t0 + 2 > vfrom) ? t0 + 2 : vfrom;
    s   = 0;
    for (int k = 0; k < len; k++) begin
      s = (nom > h + 1) ? nom : h + 1;
      push_ev(EV_EN, s, pl[base + k], cut);
      nom = s + NUM;
      h   = (s > vfrom) ? s : vfrom;
    end
    for (int j = 0; j < TAIL; j++) begin
      s = s + NUM;
      push_ev(EV_EN, s, 1'b0, cut);
    end
    d = s + 1;
    push_ev(EV_DONE, d, 1'b0, cut);
    for (int c = t0 + 1; c <= d && c <= cut; c++) busy_map[c] = 1'b1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_sig);
      #1;
      pl_idx            = hs_count - hs_base;
      rst_sig           = (cyc == rst_cyc);
      bus.start_sig     = 1'b0;
      bus.len_sig       = '0;
      foreach (starts[j]) begin
        if (starts[j].c == cyc) begin
          bus.start_sig = 1'b1;
          bus.len_sig   = LEN_W'(starts[j].len);
        end
      end
      bus.in_valid_sig  = (pl_idx < pl.size()) && (cyc >= valid_from);
      bus.in_bit_sig    = bus.in_valid_sig ? pl[pl_idx] : 1'b0;
    end
  endtask

  task automatic new_test();
    starts.delete();
    pl.delete();
    hs_base    = hs_count;
    valid_from = 0;
    rst_cyc    = -1;
  endtask

  task automatic load_bits(input int n, input logic [31:0] v);
    for (int k = 0; k < n; k++) pl.push_back(v[k]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, d, d2, len;

    // Reset with every input high.
    rst_sig          = 1'b1;
    bus.start_sig    = 1'b1;
    bus.len_sig      = LEN_W'(5);
    bus.in_valid_sig = 1'b1;
    bus.in_bit_sig   = 1'b1;
    repeat (3) @(posedge clk_sig);
    @(negedge clk_sig);
    check("rst_clr",   bus.enc_clr_sig,  1'b0);
    check("rst_en",    bus.enc_en_sig,   1'b0);
    check("rst_bit",   bus.enc_bit_sig,  1'b0);
    check("rst_busy",  bus.busy_sig,     1'b0);
    check("rst_done",  bus.done_sig,     1'b0);
    check("rst_ready", bus.in_ready_sig, 1'b0);
    @(posedge clk_sig);
    #1;
    rst_sig          = 1'b0;
    bus.start_sig    = 1'b0;
    bus.len_sig      = '0;
    bus.in_valid_sig = 1'b0;
    bus.in_bit_sig   = 1'b0;
    mon_en           = 1'b1;

    // Basic frame: len=3, bits 1,0,1, valid always.
    new_test();
    t0 = cyc + 2;
    load_bits(3, 32'b101);
    starts.push_back('{c: t0, len: 3});
    model_frame(t0, 3, 0, 0, NOCUT, d);
    run(d - cyc + 4);
    check("pending_basic", exp_q.size(), 0);

    // Same frame, valid held low until cycle 8 of the frame.
    new_test();
    t0 = cyc + 2;
    load_bits(3, 32'b101);
    valid_from = t0 + 8;
    starts.push_back('{c: t0, len: 3});
    model_frame(t0, 3, 0, t0 + 8, NOCUT, d);
    run(d - cyc + 4);
    check("pending_stall", exp_q.size(), 0);

    // Zero-length start is ignored, then a frame with a mid-frame start pulse.
    new_test();
    t0 = cyc + 2;
    starts.push_back('{c: t0, len: 0});
    run(12);
    new_test();
    t0 = cyc + 2;
    load_bits(2, 32'b10);
    starts.push_back('{c: t0, len: 2});
    starts.push_back('{c: t0 + 6, len: 7});
    model_frame(t0, 2, 0, 0, NOCUT, d);
    run(d - cyc + 4);
    check("pending_midstart", exp_q.size(), 0);

    // Reset at cycle 10 of a len=3 frame, then a normal len=4 frame.
    new_test();
    t0 = cyc + 2;
    load_bits(3, 32'b011);
    rst_cyc = t0 + 10;
    starts.push_back('{c: t0, len: 3});
    model_frame(t0, 3, 0, 0, t0 + 10, d);
    run(t0 + 16 - cyc);
    check("pending_abort", exp_q.size(), 0);
    new_test();
    t0 = cyc + 2;
    load_bits(4, 32'b1001);
    starts.push_back('{c: t0, len: 4});
    model_frame(t0, 4, 0, 0, NOCUT, d);
    run(d - cyc + 4);
    check("pending_after_abort", exp_q.size(), 0);

    // Back-to-back frames: second start in the cycle after done.
    new_test();
    t0 = cyc + 2;
    load_bits(2, 32'b11);
    load_bits(3, 32'b110);
    starts.push_back('{c: t0, len: 2});
    model_frame(t0, 2, 0, 0, NOCUT, d);
    starts.push_back('{c: d + 1, len: 3});
    model_frame(d + 1, 3, 2, 0, NOCUT, d2);
    run(d2 - cyc + 4);
    check("pending_b2b", exp_q.size(), 0);

    // Random frames with random payload and late valid.
    for (int r = 0; r < 4; r++) begin
      new_test();
      t0  = cyc + 2;
      len = int'($urandom_range(1, 6));
      load_bits(len, $urandom);
      valid_from = t0 + int'($urandom_range(0, 12));
      starts.push_back('{c: t0, len: len});
      model_frame(t0, len, 0, valid_from, NOCUT, d);
      run(d - cyc + 4);
      check($sformatf("pending_rand%0d", r), exp_q.size(), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/enc_frame_ctrl.md
# enc_frame_ctrl

Frame sequencer for the convolutional encoder path. For each frame it clears the encoder state and paces `len` payload bits into the encoder, one bit every `NUM` clocks, which is the same cadence the `div` clock divider produces. It then appends `TAIL` zero flush bits and signals completion. It sits between the upstream bit source, which uses a valid/ready handshake, and the encoder's clock-enable, clear and data inputs. It is the single owner of the encoder's step timing.

## Interface
- `NUM`, default 4: clocks per encoder bit slot; legal values are 2 or more.
- `TAIL`, default 2: number of zero flush bits per frame (K-1); legal values are 1 or more.
- `LEN_W`, default 8: width of the frame-length input.
- `clk_sig`, input, 1: single clock; all logic is on its rising edge.
- `rst_sig`, input, 1: synchronous reset, active-high.
- `start_sig`, input, 1: frame start request; sampled only in IDLE.
- `len_sig`, input, `LEN_W`: payload bit count; latched when a start is accepted.
- `in_valid_sig`, input, 1: upstream bit valid.
- `in_bit_sig`, input, 1: upstream payload bit.
- `in_ready_sig`, output, 1: the block accepts `in_bit_sig` in this cycle.
- `enc_clr_sig`, output, 1: one-cycle encoder state clear.
- `enc_en_sig`, output, 1: one-cycle encoder step strobe.
- `enc_bit_sig`, output, 1: bit presented to the encoder; valid while `enc_en_sig`=1.
- `busy_sig`, output, 1: a frame is in progress (the state is not IDLE).
- `done_sig`, output, 1: one-cycle frame-complete pulse.

## Operation
- Internal state:
  - `len_reg` (`LEN_W` bits).
  - `acc_cnt` and `emit_cnt` (`LEN_W` bits each): payload bits accepted and emitted.
  - `tail_cnt`: wide enough to hold `TAIL`.
  - Slot counter `cnt`: `$clog2(NUM)` bits, counts 0..NUM-1.
  - One-bit holding register `hold_bit` with flag `hold_v`.
- FSM states: IDLE, CLEAR, DATA, FLUSH, DONE.
- IDLE:
  - If `start_sig`=1 and `len_sig`≠0: latch `len_reg`, zero all counters and `hold_v`, go to CLEAR.
  - A start with `len_sig`=0 is ignored; the block stays in IDLE.
- CLEAR:
  - `enc_clr_sig`=1 for this one cycle.
  - Set `cnt`=0 and go to DATA.
- DATA:
  - `cnt` increments each cycle and wraps from NUM-1 to 0.
  - Tick: `cnt`==NUM-1 and `hold_v`=1.
  - On a tick: `enc_en_sig`=1, `enc_bit_sig`=`hold_bit`, and `emit_cnt` increments.
  - When the tick is the `len_reg`-th one: `cnt`←0 and go to FLUSH.
  - Stall: if `cnt`==NUM-1 and `hold_v`=0, `cnt` holds at NUM-1 with no strobe. The tick fires in the first cycle `hold_v` is 1.
- `in_ready_sig` = (state==DATA) and (`acc_cnt` < `len_reg`) and (`hold_v`=0 or a tick occurs this cycle).
  - A handshake (`in_valid_sig` and `in_ready_sig`) loads `hold_bit`, sets `hold_v` and increments `acc_cnt`.
  - A simultaneous tick and load leaves `hold_v`=1 with the new bit.
  - A tick without a load clears `hold_v`.
- FLUSH:
  - `cnt` runs 0..NUM-1 with no stall.
  - Each `cnt`==NUM-1 gives `enc_en_sig`=1 and `enc_bit_sig`=0, and increments `tail_cnt`.
  - After the `TAIL`-th strobe, go to DONE.
- DONE: `done_sig`=1 for this one cycle, then go to IDLE.
- `start_sig` outside IDLE is ignored and the running frame is unaffected.
- `enc_clr_sig`, `enc_en_sig`, `done_sig` and `in_ready_sig` are decoded from registered state only; no input-to-output combinational path exists except `in_ready_sig`'s use of the registered tick condition.
- `enc_bit_sig`=0 whenever `enc_en_sig`=0.

## Timing
- Reset (`rst_sig`=1 at an edge): state IDLE, all counters 0, `hold_v`=0. All outputs are 0 in the following cycle.
- Reset mid-frame aborts immediately. No `done_sig` and no further strobes are produced; a held bit is discarded.
- With start accepted at edge t:
  - CLEAR occupies cycle t+1.
  - DATA begins at t+2.
  - The first `enc_en_sig` is at t+NUM+1 at the earliest, provided a bit is handshaken by t+NUM.
- Strobes are spaced exactly NUM cycles apart when there is no stall. A stall of s cycles delays that strobe and all later strobes by s.
- With no stall, `done_sig` is at cycle t+2+(len+TAIL)·NUM and `busy_sig` is high for cycles t+1 through that cycle inclusive.
- A new start is accepted at the earliest in the cycle after `done_sig`.
- `len_sig`=2^LEN_W−1 is a legal length; `emit_cnt` never wraps.

## Test plan
- Reset with all inputs high: every output is 0, and `start_sig` is ignored while `rst_sig`=1.
- NUM=4, TAIL=2, len=3, bits 1,0,1, `in_valid_sig` always 1, start at t=0:
  - `enc_clr_sig` at cycle 1.
  - `enc_en_sig` at 5, 9, 13 (bits 1,0,1) and at 17, 21 (bits 0,0).
  - `done_sig` at 22.
- Same frame with `in_valid_sig` held low until cycle 8: the strobes move to 9, 13, 17, 21, 25 and `done_sig` to 26.
- `start_sig` with `len_sig`=0: `busy_sig` stays 0 and no strobes occur. A `start_sig` pulse mid-frame does not change the strobe schedule.
- `rst_sig` asserted at cycle 10 of a len=3 frame: from cycle 11 all outputs are 0. No `done_sig` is produced, and a new frame then runs normally.
- Back-to-back frames, with start asserted in the cycle after `done_sig`: the second `enc_clr_sig` occurs exactly 2 cycles after `done_sig`.
